imem_port_arbiter: RTL and testbench

- Shares the single-port 256x16 instruction memory between two requesters: the fetch stage (read-only) and the program loader/debug port (read/write).
- Sits between the fetch stage, the loader, and the instruction memory array.
- Fetch has priority by default. The loader can lock the memory for burst program loads.
- The memory is synchronous-read: address sampled at posedge, data valid the following cycle.

---
 rtl/imem_port_arbiter_if.sv | 49 ++++
 rtl/imem_port_arbiter.sv | 108 ++++++++++
 tb/tb_imem_port_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/imem_port_arbiter_if.sv
// Bundle of fetch, loader and memory-side signals for imem_port_arbiter.
// slave = arbiter side, master = requesters plus memory array.
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;

    logic              l_req;
    logic              l_we;
    logic              l_lock;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [1:0]        owner;

    modport slave (
        input  f_req, f_addr,
        input  l_req, l_we, l_lock, l_addr, l_wdata,
        input  mem_rdata,
        output f_gnt, f_rvalid, f_rdata,
        output l_gnt, l_rvalid, l_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output owner
    );

    modport master (
        output f_req, f_addr,
        output l_req, l_we, l_lock, l_addr, l_wdata,
        output mem_rdata,
        input  f_gnt, f_rvalid, f_rdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  owner
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Fetch/loader arbiter for the single-port instruction memory.
// Define IMEM_ARB_STARVE_GUARD_EN to bound loader starvation by STARVE_MAX.
module imem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input logic                clk,
    input logic                reset_n,
    imem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        LOAD   = 2'd2,
        LOCKED = 2'd3
    } state_e;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
        $error("STARVE_MAX out of range 1..15");
    end

    state_e state_q, state_d;
    logic   f_rvalid_q, l_rvalid_q;
    logic   f_gnt, l_gnt;
    logic   l_win;

`ifdef IMEM_ARB_STARVE_GUARD_EN
    logic [3:0] wait_q, wait_d;

    assign l_win = bus.l_req && (wait_q == 4'(STARVE_MAX));

    always_comb begin
        wait_d = wait_q;
        if (!bus.l_req || l_gnt) begin
            wait_d = '0;
        end else if (wait_q != 4'(STARVE_MAX)) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign l_win = 1'b0;
`endif

    // Grants are forced low while reset is held so the memory sees no access.
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (reset_n) begin
            if (state_q == LOCKED) begin
                l_gnt = bus.l_req;
            end else if (l_win) begin
                l_gnt = 1'b1;
            end else begin
                f_gnt = bus.f_req;
                l_gnt = bus.l_req & ~bus.f_req;
            end
        end
    end

    always_comb begin
        state_d = IDLE;
        if (state_q == LOCKED) begin
            state_d = bus.l_lock ? LOCKED : IDLE;
        end else if (l_gnt && bus.l_lock) begin
            state_d = LOCKED;
        end else if (f_gnt) begin
            state_d = FETCH;
        end else if (l_gnt) begin
            state_d = LOAD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            f_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            f_rvalid_q <= f_gnt;
            l_rvalid_q <= l_gnt & ~bus.l_we;
        end
    end

    assign bus.f_gnt     = f_gnt;
    assign bus.l_gnt     = l_gnt;
    assign bus.f_rvalid  = f_rvalid_q;
    assign bus.l_rvalid  = l_rvalid_q;
    assign bus.f_rdata   = bus.mem_rdata;
    assign bus.l_rdata   = bus.mem_rdata;
    assign bus.mem_en    = f_gnt | l_gnt;
    assign bus.mem_we    = l_gnt & bus.l_we;
    assign bus.mem_addr  = f_gnt ? bus.f_addr :
                           l_gnt ? bus.l_addr : '0;
    assign bus.mem_wdata = l_gnt ? bus.l_wdata : '0;
    assign bus.owner     = state_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Table-driven bench for imem_port_arbiter with a read-data scoreboard.
// Expected tables cover both builds of IMEM_ARB_STARVE_GUARD_EN.
module tb_imem_port_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    imem_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bif ();

    imem_port_arbiter #(
        .ADDR_W(8), .DATA_W(16), .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bif)
    );

    logic [15:0] mem [256];
    logic [15:0] rd_q;
    logic        preload = 1'b1;

    always @(posedge clk) begin
        if (preload) begin
            mem[8'h10] <= 16'hA5A5;
            mem[8'h30] <= 16'h3C3C;
            mem[8'hFF] <= 16'hBEEF;
            mem[8'h00] <= 16'h0F0F;
        end else if (bif.mem_en) begin
            if (bif.mem_we) mem[bif.mem_addr] <= bif.mem_wdata;
            else            rd_q <= mem[bif.mem_addr];
        end
    end
    assign bif.mem_rdata = rd_q;

    typedef struct {
        bit          fr;
        logic [7:0]  fa;
        bit          lr;
        bit          lwe;
        bit          llk;
        logic [7:0]  la;
        logic [15:0] lwd;
        bit          efg;
        bit          elg;
        logic [1:0]  eow;
        logic [15:0] ed;
    } vec_t;

    localparam int NV = 24;
    vec_t v [NV];

    logic [15:0] fq [$];
    logic [15:0] lq [$];
    int errors = 0;
    int checks = 0;
    int cyc = -1;

    function automatic vec_t mk(bit fr, logic [7:0] fa, bit lr, bit lwe,
                                bit llk, logic [7:0] la, logic [15:0] lwd,
                                bit efg, bit elg, logic [1:0] eow,
                                logic [15:0] ed);
        vec_t r;
        r.fr = fr; r.fa = fa; r.lr = lr; r.lwe = lwe; r.llk = llk;
        r.la = la; r.lwd = lwd; r.efg = efg; r.elg = elg;
        r.eow = eow; r.ed = ed;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cyc%0d %s: got %h expected %h", cyc, nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        bif.f_req   = x.fr;
        bif.f_addr  = x.fa;
        bif.l_req   = x.lr;
        bif.l_we    = x.lwe;
        bif.l_lock  = x.llk;
        bif.l_addr  = x.la;
        bif.l_wdata = x.lwd;
    endtask

    initial begin
        bit pf, pl;
        logic [7:0] ea;

        v[0]  = mk(1, 8'h10, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 2'd0, 16'hA5A5);
        v[1]  = mk(1, 8'h10, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 2'd1, 16'hA5A5);
        v[2]  = mk(1, 8'h10, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 2'd1, 16'hA5A5);
        v[3]  = mk(0, 8'h00, 1, 1, 0, 8'h20, 16'h1234, 0, 1, 2'd1, 16'h0000);
        v[4]  = mk(0, 8'h00, 1, 0, 0, 8'h20, 16'h0000, 0, 1, 2'd2, 16'h1234);
        v[5]  = mk(0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 2'd2, 16'h0000);
        v[6]  = mk(1, 8'h00, 1, 0, 0, 8'h30, 16'h0000, 1, 0, 2'd0, 16'h0F0F);
        v[7]  = mk(1, 8'h00, 1, 0, 0, 8'h30, 16'h0000, 1, 0, 2'd1, 16'h0F0F);
        v[8]  = mk(1, 8'h00, 1, 0, 0, 8'h30, 16'h0000, 1, 0, 2'd1, 16'h0F0F);
        v[9]  = mk(1, 8'hFF, 1, 0, 0, 8'h30, 16'h0000, 1, 0, 2'd1, 16'hBEEF);
`ifdef IMEM_ARB_STARVE_GUARD_EN
        v[10] = mk(1, 8'hFF, 1, 0, 0, 8'h30, 16'h0000, 0, 1, 2'd1, 16'h3C3C);
        v[11] = mk(1, 8'hFF, 1, 0, 0, 8'h30, 16'h0000, 1, 0, 2'd2, 16'hBEEF);
`else
        v[10] = mk(1, 8'hFF, 1, 0, 0, 8'h30, 16'h0000, 1, 0, 2'd1, 16'hBEEF);
        v[11] = mk(1, 8'hFF, 1, 0, 0, 8'h30, 16'h0000, 1, 0, 2'd1, 16'hBEEF);
`endif
        v[12] = mk(0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 2'd1, 16'h0000);
        v[13] = mk(0, 8'h00, 1, 0, 1, 8'hFF, 16'h0000, 0, 1, 2'd0, 16'hBEEF);
        for (int k = 14; k <= 18; k++)
            v[k] = mk(1, 8'h10, 0, 0, 1, 8'h00, 16'h0000, 0, 0, 2'd3, 16'h0000);
        v[19] = mk(1, 8'h10, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 2'd3, 16'h0000);
        v[20] = mk(1, 8'h10, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 2'd0, 16'hA5A5);
        v[21] = mk(1, 8'h10, 1, 0, 1, 8'h20, 16'h0000, 1, 0, 2'd1, 16'hA5A5);
        v[22] = mk(0, 8'h00, 1, 0, 1, 8'h20, 16'h0000, 0, 1, 2'd1, 16'h1234);
        v[23] = mk(1, 8'h10, 0, 0, 1, 8'h00, 16'h0000, 0, 0, 2'd3, 16'h0000);

        drive(mk(1, 8'h10, 1, 1, 1, 8'h20, 16'h5555, 0, 0, 2'd0, 16'h0));
        @(posedge clk); #1;
        preload = 1'b0;
        chk("rst f_gnt", bif.f_gnt, 0);
        chk("rst l_gnt", bif.l_gnt, 0);
        chk("rst mem_en", bif.mem_en, 0);
        chk("rst mem_we", bif.mem_we, 0);
        chk("rst mem_addr", bif.mem_addr, 0);
        chk("rst mem_wdata", bif.mem_wdata, 0);
        chk("rst owner", bif.owner, 0);
        chk("rst f_rvalid", bif.f_rvalid, 0);
        chk("rst l_rvalid", bif.l_rvalid, 0);

        @(posedge clk); #1;
        reset_n = 1'b1;
        pf = 0;
        pl = 0;
        for (int i = 0; i < NV; i++) begin
            cyc = i;
            drive(v[i]);
            if (v[i].efg) fq.push_back(v[i].ed);
            if (v[i].elg && !v[i].lwe) lq.push_back(v[i].ed);
            @(negedge clk);
            ea = v[i].efg ? v[i].fa : (v[i].elg ? v[i].la : 8'h00);
            chk("f_gnt", bif.f_gnt, v[i].efg);
            chk("l_gnt", bif.l_gnt, v[i].elg);
            chk("mem_en", bif.mem_en, v[i].efg | v[i].elg);
            chk("mem_we", bif.mem_we, v[i].elg & v[i].lwe);
            chk("mem_addr", bif.mem_addr, ea);
            chk("mem_wdata", bif.mem_wdata, v[i].elg ? v[i].lwd : 16'h0);
            chk("owner", bif.owner, v[i].eow);
            chk("f_rvalid", bif.f_rvalid, pf);
            chk("l_rvalid", bif.l_rvalid, pl);
            if (bif.f_rvalid && fq.size() > 0)
                chk("f_rdata", bif.f_rdata, fq.pop_front());
            if (bif.l_rvalid && lq.size() > 0)
                chk("l_rdata", bif.l_rdata, lq.pop_front());
            pf = v[i].efg;
            pl = v[i].elg & ~v[i].lwe;
            @(posedge clk); #1;
        end

        cyc = 100;
        drive(mk(0, 8'h00, 1, 0, 1, 8'h10, 16'h0000, 0, 0, 2'd0, 16'h0));
        @(negedge clk);
        chk("lock rd l_gnt", bif.l_gnt, 1);
        chk("lock rd owner", bif.owner, 3);
        @(posedge clk); #1;
        chk("lock rd l_rvalid", bif.l_rvalid, 1);
        bif.f_req = 1'b1;
        reset_n = 1'b0;
        #1;
        fq.delete();
        lq.delete();
        chk("midrst l_rvalid", bif.l_rvalid, 0);
        chk("midrst owner", bif.owner, 0);
        chk("midrst mem_en", bif.mem_en, 0);
        chk("midrst f_gnt", bif.f_gnt, 0);
        chk("midrst l_gnt", bif.l_gnt, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        drive(mk(1, 8'h10, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 2'd0, 16'h0));
        @(negedge clk);
        chk("post f_gnt", bif.f_gnt, 1);
        chk("post owner", bif.owner, 0);
        chk("post l_rvalid", bif.l_rvalid, 0);
        @(posedge clk); #1;
        drive(mk(0, 8'h00, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 2'd0, 16'h0));
        @(negedge clk);
        chk("post f_rvalid", bif.f_rvalid, 1);
        chk("post f_rdata", bif.f_rdata, 16'hA5A5);
        chk("post owner2", bif.owner, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
